// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: two-port (instruction/data) arbiter onto one shared memory bus.
// Round-robin on ties, one transfer in flight, single-cycle ready/error pulse per response.
// Optional macro ELBETH_ARB_TIMEOUT_EN adds a busy-cycle watchdog that aborts with error.
module elbeth_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_en,
  input  logic [13:0] imem_addr,
  input  logic [3:0]  imem_rw,
  input  logic [31:0] imem_wdata,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,
  input  logic        dmem_en,
  input  logic [13:0] dmem_addr,
  input  logic [3:0]  dmem_rw,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,
  output logic        bus_req,
  output logic [13:0] bus_addr,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int unsigned AW = 14;
  localparam int unsigned MW = 4;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  // Reject a watchdog length the 4-bit counter cannot represent
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("elbeth_mem_arbiter: TIMEOUT_CYCLES must be in 1..15");
  end

  state_t          r_state, w_state;
  logic            r_last_d, w_last_d;
  logic            r_bus_req, w_bus_req;
  logic [AW-1:0]   r_bus_addr, w_bus_addr;
  logic [MW-1:0]   r_bus_we, w_bus_we;
  logic [DW-1:0]   r_bus_wdata, w_bus_wdata;
  logic [DW-1:0]   r_imem_rdata, w_imem_rdata;
  logic [DW-1:0]   r_dmem_rdata, w_dmem_rdata;
  logic            r_imem_ready, w_imem_ready;
  logic            r_imem_error, w_imem_error;
  logic            r_dmem_ready, w_dmem_ready;
  logic            r_dmem_error, w_dmem_error;

  logic            w_busy;
  logic            w_grant_d;
  logic            w_tmo;
  logic            w_fail;
  logic            w_done;
  logic [DW-1:0]   w_rdata;

  assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
  // Data wins when it is alone or when instruction was served last
  assign w_grant_d = dmem_en && (!imem_en || !r_last_d);
  assign w_fail    = bus_err || w_tmo;
  assign w_done    = bus_ack || w_fail;
  assign w_rdata   = w_fail ? '0 : bus_rdata;

`ifdef ELBETH_ARB_TIMEOUT_EN
  logic [3:0] r_tmo_cnt;

  // Watchdog: counts busy cycles that end without a bus completion, idle at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= 4'd0;
    end else if (w_busy && !w_done) begin
      r_tmo_cnt <= r_tmo_cnt + 4'd1;
    end else begin
      r_tmo_cnt <= 4'd0;
    end
  end

  assign w_tmo = w_busy && !bus_ack && !bus_err && (r_tmo_cnt == 4'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // State and registered-output update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_d     <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_we     <= '0;
      r_bus_wdata  <= '0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
      r_imem_ready <= 1'b0;
      r_imem_error <= 1'b0;
      r_dmem_ready <= 1'b0;
      r_dmem_error <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_d     <= w_last_d;
      r_bus_req    <= w_bus_req;
      r_bus_addr   <= w_bus_addr;
      r_bus_we     <= w_bus_we;
      r_bus_wdata  <= w_bus_wdata;
      r_imem_rdata <= w_imem_rdata;
      r_dmem_rdata <= w_dmem_rdata;
      r_imem_ready <= w_imem_ready;
      r_imem_error <= w_imem_error;
      r_dmem_ready <= w_dmem_ready;
      r_dmem_error <= w_dmem_error;
    end
  end

  // Next state and next register values; ready/error are single-cycle pulses
  always_comb begin
    w_state      = r_state;
    w_last_d     = r_last_d;
    w_bus_req    = r_bus_req;
    w_bus_addr   = r_bus_addr;
    w_bus_we     = r_bus_we;
    w_bus_wdata  = r_bus_wdata;
    w_imem_rdata = r_imem_rdata;
    w_dmem_rdata = r_dmem_rdata;
    w_imem_ready = 1'b0;
    w_imem_error = 1'b0;
    w_dmem_ready = 1'b0;
    w_dmem_error = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state     = BUSY_D;
          w_last_d    = 1'b1;
          w_bus_req   = 1'b1;
          w_bus_addr  = dmem_addr;
          w_bus_we    = dmem_rw;
          w_bus_wdata = dmem_wdata;
        end else if (imem_en) begin
          w_state     = BUSY_I;
          w_last_d    = 1'b0;
          w_bus_req   = 1'b1;
          w_bus_addr  = imem_addr;
          w_bus_we    = imem_rw;
          w_bus_wdata = imem_wdata;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_done) begin
          w_state   = RESP;
          w_bus_req = 1'b0;
          if (r_state == BUSY_D) begin
            w_dmem_ready = 1'b1;
            w_dmem_error = w_fail;
            w_dmem_rdata = w_rdata;
          end else begin
            w_imem_ready = 1'b1;
            w_imem_error = w_fail;
            w_imem_rdata = w_rdata;
          end
        end
      end
      RESP: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign bus_req    = r_bus_req;
  assign bus_addr   = r_bus_addr;
  assign bus_we     = r_bus_we;
  assign bus_wdata  = r_bus_wdata;
  assign imem_rdata = r_imem_rdata;
  assign imem_ready = r_imem_ready;
  assign imem_error = r_imem_error;
  assign dmem_rdata = r_dmem_rdata;
  assign dmem_ready = r_dmem_ready;
  assign dmem_error = r_dmem_error;

endmodule
